if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined RV32 core.
- Owns the PC register and drives the word offset into the 64-word instruction memory, which returns the instruction combinationally.
- Latches the fetched instruction into the IF/ID pipeline register.
- Handles load-use stalls, branch/jump redirects and ECALL/EBREAK halt, and injects bubbles into ID.

Parameters:
- RESET_PC, 32'h00000000: PC value loaded on reset.
- NOP_INST, 32'h00000033: bubble encoding (add x0,x0,x0).
- OFFSET_W, 6: instruction-memory word-offset width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- stall  input  1  hazard unit: hold PC and IF/ID.
- redirect  input  1  branch/jump resolved taken; flush and load target.
- redirect_pc  input  32  redirect target byte address.
- imem_offset  output  OFFSET_W  word offset to instruction memory = pc[OFFSET_W+1:2].
- imem_data  input  32  instruction returned by instruction memory (combinational).
- pc  output  32  current fetch PC.
- if_id_pc  output  32  PC of instruction in IF/ID.
- if_id_pc4  output  32  if_id_pc + 4.
- if_id_inst  output  32  instruction in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch stopped after ECALL/EBREAK.
- misalign_err  output  1  sticky: a redirect target had nonzero bits [1:0].

Behaviour:
- Reset: when rst_n=0 at a clock edge:
  - pc=RESET_PC, if_id_pc=0, if_id_pc4=0, if_id_inst=NOP_INST, if_id_valid=0.
  - halted=0, misalign_err=0, state=RUN.
  - Reset mid-operation discards all in-flight state regardless of other inputs.
- imem_offset is purely combinational from pc. No extra latency: the instruction at pc appears in IF/ID one edge after pc is presented.
- States: RUN, HALT. halted=1 iff state=HALT.
- Per-edge priority: reset > redirect > stall > HALT hold > normal fetch.
- RUN, normal (no redirect, no stall):
  - if_id_inst<=imem_data, if_id_pc<=pc, if_id_pc4<=pc+4, if_id_valid<=1.
  - If imem_data is 32'h00000073 (ECALL) or 32'h00100073 (EBREAK): the instruction is still latched, pc holds, state->HALT.
  - Otherwise pc<=pc+4.
- Stall (no redirect): pc, IF/ID and state all hold. A stall does not trigger ECALL detection.
- Redirect (any state, overrides stall):
  - pc<={redirect_pc[31:2],2'b00}.
  - IF/ID <= bubble: inst=NOP_INST, valid=0, if_id_pc/if_id_pc4 hold.
  - state->RUN. This covers a wrong-path ECALL that was squashed.
  - If redirect_pc[1:0]!=0: misalign_err<=1 (sticky until reset).
- HALT (no redirect): pc holds. IF/ID <= bubble every edge regardless of stall, except that with stall=1 IF/ID holds. Exit only via redirect or reset.
- Arithmetic: pc+4 is modulo 2^32 (0xFFFFFFFC -> 0x00000000). imem_offset uses only pc[7:2], so the 64-word memory aliases every 256 bytes; this is not an error.
- Simultaneous redirect + ECALL fetch in the same cycle: redirect wins, no halt.

Test Plan:
- Reset then free-run with mem[0..2] = lb, lb, add -> pc 0,4,8,12. if_id_pc 0,4,8 with matching if_id_inst. if_id_valid rises one cycle after reset release. imem_offset 0,1,2,3.
- stall=1 for 2 cycles at pc=8 -> pc stays 8, if_id_inst stays mem[1]. Release -> mem[2] is latched, pc=12.
- redirect=1 with redirect_pc=32'h20 and stall=1 on the same edge -> pc=0x20, if_id_valid=0, if_id_inst=NOP_INST. Next edge latches mem[8] with if_id_pc=0x20.
- mem[4]=ECALL -> after it latches: halted=1, pc=16. Following edges give if_id_valid=0. Then redirect_pc=0x0C -> halted=0, fetch resumes at mem[3].
- redirect_pc=32'h0000000E -> pc=0x0C, misalign_err=1, and it stays 1 through later redirects until rst_n=0.
- rst_n=0 while halted with misalign_err=1 and pc=0x40 -> next edge: pc=0, halted=0, misalign_err=0, if_id_inst=NOP_INST, if_id_valid=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction-memory word
// offset, fills the IF/ID register, and handles stall, redirect and ECALL/EBREAK halt.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0033,
  parameter int          OFFSET_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic [OFFSET_W-1:0] imem_offset,
  input  logic [31:0]         imem_data,
  output logic [31:0]         pc,
  output logic [31:0]         if_id_pc,
  output logic [31:0]         if_id_pc4,
  output logic [31:0]         if_id_inst,
  output logic                if_id_valid,
  output logic                halted,
  output logic                misalign_err
);

  localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic {RUN, HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_if_id_pc, w_if_id_pc_nxt;
  logic [31:0] r_if_id_pc4, w_if_id_pc4_nxt;
  logic [31:0] r_if_id_inst, w_if_id_inst_nxt;
  logic        r_if_id_valid, w_if_id_valid_nxt;
  logic        r_misalign, w_misalign_nxt;
  logic [31:0] w_pc_plus4;
  logic        w_is_sys;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_is_sys   = (imem_data == ECALL_INST) || (imem_data == EBREAK_INST);

  // Priority below reset: redirect > stall > halt hold > normal fetch.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_id_pc_nxt    = r_if_id_pc;
    w_if_id_pc4_nxt   = r_if_id_pc4;
    w_if_id_inst_nxt  = r_if_id_inst;
    w_if_id_valid_nxt = r_if_id_valid;
    w_misalign_nxt    = r_misalign;
    if (redirect) begin
      w_pc_nxt          = {redirect_pc[31:2], 2'b00};
      w_if_id_inst_nxt  = NOP_INST;
      w_if_id_valid_nxt = 1'b0;
      w_state_nxt       = RUN;
      if (redirect_pc[1:0] != 2'b00) w_misalign_nxt = 1'b1;
    end else if (stall) begin
      w_state_nxt = r_state;
    end else if (r_state == HALT) begin
      w_if_id_inst_nxt  = NOP_INST;
      w_if_id_valid_nxt = 1'b0;
    end else begin
      w_if_id_inst_nxt  = imem_data;
      w_if_id_pc_nxt    = r_pc;
      w_if_id_pc4_nxt   = w_pc_plus4;
      w_if_id_valid_nxt = 1'b1;
      // A system instruction is still handed to ID, but fetch parks on it.
      if (w_is_sys) w_state_nxt = HALT;
      else          w_pc_nxt    = w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_if_id_pc    <= 32'd0;
      r_if_id_pc4   <= 32'd0;
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_id_pc    <= w_if_id_pc_nxt;
      r_if_id_pc4   <= w_if_id_pc4_nxt;
      r_if_id_inst  <= w_if_id_inst_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_misalign    <= w_misalign_nxt;
    end
  end

  assign imem_offset  = r_pc[OFFSET_W+1:2];
  assign pc           = r_pc;
  assign if_id_pc     = r_if_id_pc;
  assign if_id_pc4    = r_if_id_pc4;
  assign if_id_inst   = r_if_id_inst;
  assign if_id_valid  = r_if_id_valid;
  assign halted       = (r_state == HALT);
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed test-plan scenarios plus randomized traffic, all
// checked every cycle against a behavioural fetch model with its own memory.
module tb_if_stage;

  localparam logic [31:0] NOP    = 32'h0000_0033;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [5:0]  imem_offset;
  logic [31:0] imem_data;
  logic [31:0] pc, if_id_pc, if_id_pc4, if_id_inst;
  logic        if_id_valid, halted, misalign_err;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_offset];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_offset(imem_offset), .imem_data(imem_data),
    .pc(pc), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_inst(if_id_inst),
    .if_id_valid(if_id_valid), .halted(halted), .misalign_err(misalign_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc = 0, m_ifpc = 0, m_ifpc4 = 0, m_inst = 0;
  logic        m_valid = 0, m_halt = 0, m_mis = 0, m_known = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    logic [31:0] word;
    word = mem[m_pc[7:2]];
    if (!rst_n) begin
      m_pc = 32'd0; m_ifpc = 32'd0; m_ifpc4 = 32'd0; m_inst = NOP;
      m_valid = 0; m_halt = 0; m_mis = 0; m_known = 1;
    end else if (redirect) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_inst = NOP; m_valid = 0; m_halt = 0;
      if (redirect_pc % 4 != 0) m_mis = 1;
    end else if (stall) begin
      // everything holds
    end else if (m_halt) begin
      m_inst = NOP; m_valid = 0;
    end else begin
      m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_inst = word; m_valid = 1;
      if (word == ECALL || word == EBREAK) m_halt = 1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock: check the combinational offset, step the model, compare after the edge.
  task automatic tick();
    if (m_known) check("imem_offset", {26'd0, imem_offset}, {26'd0, m_pc[7:2]});
    model_step();
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("if_id_pc", if_id_pc, m_ifpc);
    check("if_id_pc4", if_id_pc4, m_ifpc4);
    check("if_id_inst", if_id_inst, m_inst);
    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check("halted", {31'd0, halted}, {31'd0, m_halt});
    check("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
  endtask

  function automatic logic [31:0] rand_plain();
    logic [31:0] w;
    w = $urandom;
    if (w == ECALL || w == EBREAK) w = w ^ 32'h100;
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = rand_plain();
    mem[0]  = 32'h0000_0083;   // lb x1,0(x0)
    mem[1]  = 32'h0040_0103;   // lb x2,4(x0)
    mem[2]  = 32'h0020_81b3;   // add x3,x1,x2
    mem[4]  = ECALL;
    mem[16] = EBREAK;

    // Reset
    rst_n = 0;
    tick(); tick();
    check("lit_reset_pc", pc, 32'h0);
    check("lit_reset_inst", if_id_inst, NOP);
    check("lit_reset_valid", {31'd0, if_id_valid}, 32'd0);

    // Free-run
    rst_n = 1;
    tick();
    check("lit_run_pc4", pc, 32'h4);
    check("lit_run_inst0", if_id_inst, 32'h0000_0083);
    check("lit_run_valid", {31'd0, if_id_valid}, 32'd1);
    tick();
    check("lit_run_ifpc4", if_id_pc, 32'h4);
    check("lit_run_off2", {26'd0, imem_offset}, 32'd2);

    // Stall two cycles at pc=8
    stall = 1;
    tick(); tick();
    check("lit_stall_pc", pc, 32'h8);
    check("lit_stall_inst", if_id_inst, 32'h0040_0103);
    stall = 0;
    tick();
    check("lit_release_inst", if_id_inst, 32'h0020_81b3);
    check("lit_release_pc", pc, 32'hC);

    // Redirect overrides stall
    redirect = 1; redirect_pc = 32'h20; stall = 1;
    tick();
    check("lit_redir_pc", pc, 32'h20);
    check("lit_redir_inst", if_id_inst, NOP);
    redirect = 0; stall = 0;
    tick();
    check("lit_redir_fetch", if_id_inst, mem[8]);
    check("lit_redir_ifpc", if_id_pc, 32'h20);

    // ECALL halt and resume
    redirect = 1; redirect_pc = 32'h10;
    tick();
    redirect = 0;
    tick();
    check("lit_ecall_halted", {31'd0, halted}, 32'd1);
    check("lit_ecall_pc", pc, 32'h10);
    check("lit_ecall_inst", if_id_inst, ECALL);
    tick(); tick();
    check("lit_halt_bubble", {31'd0, if_id_valid}, 32'd0);
    redirect = 1; redirect_pc = 32'h0C;
    tick();
    check("lit_resume_halted", {31'd0, halted}, 32'd0);
    redirect = 0;
    tick();
    check("lit_resume_inst", if_id_inst, mem[3]);

    // Misaligned redirect, stickiness, then halt at 0x40 and reset
    redirect = 1; redirect_pc = 32'h0000_000E;
    tick();
    check("lit_mis_pc", pc, 32'hC);
    check("lit_mis_err", {31'd0, misalign_err}, 32'd1);
    redirect_pc = 32'h40;
    tick();
    redirect = 0;
    tick();
    check("lit_mis_sticky", {31'd0, misalign_err}, 32'd1);
    check("lit_ebreak_halt", {31'd0, halted}, 32'd1);
    check("lit_ebreak_pc", pc, 32'h40);
    rst_n = 0;
    tick();
    check("lit_rst2_pc", pc, 32'h0);
    check("lit_rst2_mis", {31'd0, misalign_err}, 32'd0);
    check("lit_rst2_halt", {31'd0, halted}, 32'd0);
    check("lit_rst2_inst", if_id_inst, NOP);
    rst_n = 1;

    // PC wrap-around
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 0;
    tick();
    check("lit_wrap_pc", pc, 32'h0);
    check("lit_wrap_pc4", if_id_pc4, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 64; i++) begin
      mem[i] = rand_plain();
      if ($urandom_range(0, 7) == 0) mem[i] = ($urandom_range(0, 1) == 0) ? ECALL : EBREAK;
    end
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 99) >= 2);
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = {24'd0, $urandom_range(0, 255) & 32'hFC};
        1: redirect_pc = $urandom;
        2: redirect_pc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
        default: redirect_pc = {24'd0, 8'($urandom_range(0, 255))};
      endcase
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
